// File: rtl/alu_core.sv
// Registered ALU responder: arithmetic/logical command sets, operand-wait window for
// split operand delivery, and a two-cycle multiply path.
module alu_core #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned CMD_WIDTH   = 3,
  parameter int unsigned WAIT_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 RST,
  input  logic                 CE,
  input  logic [1:0]           INP_VALID,
  input  logic                 MODE,
  input  logic [CMD_WIDTH:0]   CMD,
  input  logic [WIDTH-1:0]     OPA,
  input  logic [WIDTH-1:0]     OPB,
  input  logic                 CIN,
  output logic [WIDTH:0]       RES,
  output logic                 COUT,
  output logic                 OFLOW,
  output logic                 G,
  output logic                 L,
  output logic                 E,
  output logic                 ERR
);

  localparam int unsigned CntW = $clog2(WAIT_CYCLES + 1);
  localparam int unsigned ShW  = $clog2(WIDTH);
  localparam int unsigned PW   = 2 * WIDTH + 2;
  localparam logic [WIDTH:0]  One    = 1;
  localparam logic [CntW-1:0] CntOne = 1;

  typedef enum logic [1:0] {StIdle, StWait, StMul} state_e;
  typedef enum logic [1:0] {KTwo, KOnlyA, KOnlyB, KNone} kind_e;

  typedef struct packed {
    logic [WIDTH:0] res;
    logic           cout;
    logic           oflow;
    logic           g;
    logic           l;
    logic           e;
    logic           err;
  } out_t;

  function automatic kind_e kind_of(input logic mode, input logic [3:0] c);
    if (mode) begin
      case (c)
        4'd0, 4'd1, 4'd2, 4'd3, 4'd8, 4'd9, 4'd10: return KTwo;
        4'd4, 4'd5:                                return KOnlyA;
        4'd6, 4'd7:                                return KOnlyB;
        default:                                   return KNone;
      endcase
    end else begin
      case (c)
        4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd12, 4'd13: return KTwo;
        4'd6, 4'd8, 4'd9:                                 return KOnlyA;
        4'd7, 4'd10, 4'd11:                               return KOnlyB;
        default:                                          return KNone;
      endcase
    end
  endfunction

  function automatic logic is_mul(input logic mode, input logic [3:0] c);
    return mode && (c == 4'd9 || c == 4'd10);
  endfunction

  state_e               state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d, cnt_inc;
  logic                 lat_mode_q, lat_mode_d, lat_cin_q, lat_cin_d;
  logic [CMD_WIDTH:0]   lat_cmd_q, lat_cmd_d;
  logic [WIDTH-1:0]     lat_a_q, lat_a_d, lat_b_q, lat_b_d;
  logic                 lat_va_q, lat_va_d, lat_vb_q, lat_vb_d;
  out_t                 out_q, out_d, calc, err_out;

  logic                 sel_mode, sel_cin;
  logic [CMD_WIDTH:0]   sel_cmd;
  logic [WIDTH-1:0]     sel_a, sel_b;
  logic [3:0]           c;
  logic [WIDTH:0]       a_x, b_x;
  logic [PW-1:0]        prod;
  logic [2*WIDTH-1:0]   dbl_l, dbl_r;

  // In WAIT the latched operand wins over the bus; MUL works purely from latches.
  always_comb begin
    sel_mode = MODE;
    sel_cmd  = CMD;
    sel_cin  = CIN;
    sel_a    = OPA;
    sel_b    = OPB;
    unique case (state_q)
      StWait: begin
        sel_mode = lat_mode_q;
        sel_cmd  = lat_cmd_q;
        sel_cin  = lat_cin_q;
        sel_a    = lat_va_q ? lat_a_q : OPA;
        sel_b    = lat_vb_q ? lat_b_q : OPB;
      end
      StMul: begin
        sel_mode = lat_mode_q;
        sel_cmd  = lat_cmd_q;
        sel_cin  = lat_cin_q;
        sel_a    = lat_a_q;
        sel_b    = lat_b_q;
      end
      default: ;
    endcase
  end

  always_comb begin
    calc  = '0;
    c     = 4'(sel_cmd);
    a_x   = {1'b0, sel_a};
    b_x   = {1'b0, sel_b};
    prod  = '0;
    dbl_l = {sel_a, sel_a} << sel_b[ShW-1:0];
    dbl_r = {sel_a, sel_a} >> sel_b[ShW-1:0];
    if (sel_mode) begin
      case (c)
        4'd0: begin calc.res = a_x + b_x; calc.cout = calc.res[WIDTH]; end
        4'd1: begin calc.res = a_x - b_x; calc.oflow = (a_x < b_x); end
        4'd2: begin
          calc.res  = a_x + b_x + {{WIDTH{1'b0}}, sel_cin};
          calc.cout = calc.res[WIDTH];
        end
        4'd3: begin
          calc.res   = a_x - b_x - {{WIDTH{1'b0}}, sel_cin};
          calc.oflow = (a_x < (b_x + {{WIDTH{1'b0}}, sel_cin}));
        end
        4'd4: calc.res = a_x + One;
        4'd5: calc.res = a_x - One;
        4'd6: calc.res = b_x + One;
        4'd7: calc.res = b_x - One;
        4'd8: begin
          calc.g = (sel_a > sel_b);
          calc.l = (sel_a < sel_b);
          calc.e = (sel_a == sel_b);
        end
        4'd9, 4'd10: begin
          if (c == 4'd9) prod = PW'(a_x + One) * PW'(b_x + One);
          else           prod = PW'({sel_a, 1'b0}) * PW'(b_x);
          calc.res   = prod[WIDTH:0];
          calc.oflow = |prod[PW-1:WIDTH+1];
        end
        default: calc.err = 1'b1;
      endcase
    end else begin
      case (c)
        4'd0:  calc.res = {1'b0, sel_a & sel_b};
        4'd1:  calc.res = {1'b0, ~(sel_a & sel_b)};
        4'd2:  calc.res = {1'b0, sel_a | sel_b};
        4'd3:  calc.res = {1'b0, ~(sel_a | sel_b)};
        4'd4:  calc.res = {1'b0, sel_a ^ sel_b};
        4'd5:  calc.res = {1'b0, ~(sel_a ^ sel_b)};
        4'd6:  calc.res = {1'b0, ~sel_a};
        4'd7:  calc.res = {1'b0, ~sel_b};
        4'd8:  calc.res = {1'b0, sel_a >> 1};
        4'd9:  calc.res = {1'b0, sel_a << 1};
        4'd10: calc.res = {1'b0, sel_b >> 1};
        4'd11: calc.res = {1'b0, sel_b << 1};
        4'd12, 4'd13: begin
          calc.res = (c == 4'd12) ? {1'b0, dbl_l[2*WIDTH-1:WIDTH]} : {1'b0, dbl_r[WIDTH-1:0]};
          calc.err = |sel_b[WIDTH-1:ShW];
        end
        default: calc.err = 1'b1;
      endcase
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cnt_inc    = cnt_q + CntOne;
    lat_mode_d = lat_mode_q;
    lat_cmd_d  = lat_cmd_q;
    lat_cin_d  = lat_cin_q;
    lat_a_d    = lat_a_q;
    lat_b_d    = lat_b_q;
    lat_va_d   = lat_va_q;
    lat_vb_d   = lat_vb_q;
    out_d      = out_q;
    err_out     = '0;
    err_out.err = 1'b1;
    if (CE) begin
      unique case (state_q)
        StIdle: begin
          if (INP_VALID == 2'b00) begin
            out_d = err_out;
          end else begin
            unique case (kind_of(MODE, 4'(CMD)))
              KOnlyA: out_d = INP_VALID[0] ? calc : err_out;
              KOnlyB: out_d = INP_VALID[1] ? calc : err_out;
              KTwo: begin
                lat_mode_d = MODE;
                lat_cmd_d  = CMD;
                lat_cin_d  = CIN;
                lat_a_d    = OPA;
                lat_b_d    = OPB;
                if (INP_VALID == 2'b11) begin
                  if (is_mul(MODE, 4'(CMD))) state_d = StMul;
                  else                       out_d   = calc;
                end else begin
                  lat_va_d = INP_VALID[0];
                  lat_vb_d = INP_VALID[1];
                  cnt_d    = CntOne;
                  state_d  = StWait;
                end
              end
              default: out_d = calc;
            endcase
          end
        end
        StWait: begin
          if (INP_VALID == 2'b11) begin
            lat_a_d = sel_a;
            lat_b_d = sel_b;
            cnt_d   = '0;
            if (is_mul(lat_mode_q, 4'(lat_cmd_q))) begin
              state_d = StMul;
            end else begin
              out_d   = calc;
              state_d = StIdle;
            end
          end else if (cnt_inc == CntW'(WAIT_CYCLES)) begin
            out_d   = err_out;
            cnt_d   = '0;
            state_d = StIdle;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        StMul: begin
          out_d   = calc;
          state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      lat_mode_q <= 1'b0;
      lat_cmd_q  <= '0;
      lat_cin_q  <= 1'b0;
      lat_a_q    <= '0;
      lat_b_q    <= '0;
      lat_va_q   <= 1'b0;
      lat_vb_q   <= 1'b0;
      out_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      lat_mode_q <= lat_mode_d;
      lat_cmd_q  <= lat_cmd_d;
      lat_cin_q  <= lat_cin_d;
      lat_a_q    <= lat_a_d;
      lat_b_q    <= lat_b_d;
      lat_va_q   <= lat_va_d;
      lat_vb_q   <= lat_vb_d;
      out_q      <= out_d;
    end
  end

  assign RES   = out_q.res;
  assign COUT  = out_q.cout;
  assign OFLOW = out_q.oflow;
  assign G     = out_q.g;
  assign L     = out_q.l;
  assign E     = out_q.e;
  assign ERR   = out_q.err;

endmodule

// File: tb/tb_alu_core.sv
// Scoreboard bench for alu_core: directed vectors push expected outputs tagged with the
// cycle they must appear; a negedge monitor pops and compares.
module tb_alu_core;

  logic       clk = 1'b0;
  logic       RST = 1'b0;
  logic       CE = 1'b0;
  logic [1:0] INP_VALID = 2'b00;
  logic       MODE = 1'b0;
  logic [3:0] CMD = 4'd0;
  logic [7:0] OPA = 8'd0;
  logic [7:0] OPB = 8'd0;
  logic       CIN = 1'b0;
  logic [8:0] RES;
  logic       COUT, OFLOW, G, L, E, ERR;

  alu_core #(.WIDTH(8), .CMD_WIDTH(3), .WAIT_CYCLES(16)) dut (
    .clk(clk), .RST(RST), .CE(CE), .INP_VALID(INP_VALID), .MODE(MODE), .CMD(CMD),
    .OPA(OPA), .OPB(OPB), .CIN(CIN), .RES(RES), .COUT(COUT), .OFLOW(OFLOW),
    .G(G), .L(L), .E(E), .ERR(ERR)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Flag order in expectations: {COUT, OFLOW, G, L, E, ERR}
  typedef struct {
    string      name;
    int         due;
    logic [8:0] res;
    logic [5:0] flags;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic push(input string n, input int due, input logic [8:0] r, input logic [5:0] f);
    exp_t x;
    x.name  = n;
    x.due   = due;
    x.res   = r;
    x.flags = f;
    sb.push_back(x);
  endtask

  always @(negedge clk) begin
    exp_t x;
    while (sb.size() != 0 && sb[0].due <= cyc) begin
      x = sb.pop_front();
      n_cmp++;
      if (x.due != cyc || RES !== x.res || {COUT, OFLOW, G, L, E, ERR} !== x.flags) begin
        n_bad++;
        $display("FAIL %s: got RES=%h flags=%b, required RES=%h flags=%b (cycle %0d, due %0d)",
                 x.name, RES, {COUT, OFLOW, G, L, E, ERR}, x.res, x.flags, cyc, x.due);
      end
    end
  end

  task automatic drive(input logic ce, input logic [1:0] iv, input logic mode,
                       input logic [3:0] cmd, input logic [7:0] a, input logic [7:0] b,
                       input logic cin);
    @(negedge clk);
    CE = ce; INP_VALID = iv; MODE = mode; CMD = cmd; OPA = a; OPB = b; CIN = cin;
  endtask

  task automatic idle();
    drive(1'b0, 2'b00, 1'b0, 4'd0, 8'h00, 8'h00, 1'b0);
  endtask

  task automatic op(input string n, input logic [1:0] iv, input logic mode, input logic [3:0] cmd,
                    input logic [7:0] a, input logic [7:0] b, input logic cin,
                    input logic [8:0] r, input logic [5:0] f);
    drive(1'b1, iv, mode, cmd, a, b, cin);
    push(n, cyc + 1, r, f);
    idle();
  endtask

  task automatic mul(input string n, input logic [3:0] cmd, input logic [7:0] a,
                     input logic [7:0] b, input logic [8:0] r, input logic [5:0] f);
    drive(1'b1, 2'b11, 1'b1, cmd, a, b, 1'b0);
    push(n, cyc + 2, r, f);
    // CE must stay high for the MUL cycle; its inputs are ignored.
    drive(1'b1, 2'b00, 1'b0, 4'd0, 8'h00, 8'h00, 1'b0);
    idle();
  endtask

  initial begin
    int k;
    @(negedge clk);
    push("reset_state", cyc + 1, 9'h000, 6'b000000);
    @(negedge clk);
    RST = 1'b1;
    idle();

    op("add_ff_01", 2'b11, 1'b1, 4'd0, 8'hFF, 8'h01, 1'b0, 9'h100, 6'b100000);
    op("cmp_lt",    2'b11, 1'b1, 4'd8, 8'd5,  8'd9,  1'b0, 9'h000, 6'b000100);
    op("cmp_eq",    2'b11, 1'b1, 4'd8, 8'd7,  8'd7,  1'b0, 9'h000, 6'b000010);
    op("cmp_gt",    2'b11, 1'b1, 4'd8, 8'd9,  8'd5,  1'b0, 9'h000, 6'b001000);
    mul("mul_inc_3_4",  4'd9,  8'd3,  8'd4,  9'd20,   6'b000000);
    mul("mul_inc_ff",   4'd9,  8'hFF, 8'hFF, 9'h000,  6'b010000);
    mul("mul_shl_3_5",  4'd10, 8'd3,  8'd5,  9'd30,   6'b000000);

    // Split AND: OPA first, OPB on the fifth cycle; bus OPA and new MODE/CMD must be ignored.
    drive(1'b1, 2'b01, 1'b0, 4'd0, 8'hF0, 8'h55, 1'b0);
    push("wait_hold", cyc + 1, 9'd30, 6'b000000);
    for (int i = 0; i < 3; i++) drive(1'b1, 2'b01, 1'b0, 4'd0, 8'h11, 8'h55, 1'b0);
    drive(1'b1, 2'b11, 1'b1, 4'd1, 8'h00, 8'h3C, 1'b0);
    push("split_and", cyc + 1, 9'h030, 6'b000000);
    idle();

    // Timeout: OPB never arrives.
    for (int i = 1; i <= 16; i++) begin
      drive(1'b1, 2'b01, 1'b0, 4'd2, 8'h0F, 8'h00, 1'b0);
      if (i == 1) begin
        k = cyc;
        push("timeout_not_early", k + 15, 9'h030, 6'b000000);
        push("timeout_err",       k + 16, 9'h000, 6'b000001);
      end
    end
    idle();

    op("rol_81_01", 2'b11, 1'b0, 4'd12, 8'h81, 8'h01, 1'b0, 9'h003, 6'b000000);
    op("rol_81_11", 2'b11, 1'b0, 4'd12, 8'h81, 8'h11, 1'b0, 9'h003, 6'b000001);
    op("xor",       2'b11, 1'b0, 4'd4,  8'h0F, 8'hFF, 1'b0, 9'h0F0, 6'b000000);

    // CE low for three cycles mid-WAIT pushes the timeout out by three cycles.
    for (int i = 1; i <= 19; i++) begin
      drive((i >= 5 && i <= 7) ? 1'b0 : 1'b1, 2'b01, 1'b0, 4'd0, 8'h3C, 8'h00, 1'b0);
      if (i == 1) begin
        k = cyc;
        push("ce_freeze_hold", k + 18, 9'h0F0, 6'b000000);
        push("ce_freeze_err",  k + 19, 9'h000, 6'b000001);
      end
    end
    idle();

    // Async reset mid-WAIT clears outputs before any clock edge and drops the pending op.
    drive(1'b1, 2'b01, 1'b0, 4'd0, 8'hAA, 8'h00, 1'b0);
    drive(1'b1, 2'b01, 1'b0, 4'd0, 8'hAA, 8'h00, 1'b0);
    @(posedge clk);
    #2;
    RST = 1'b0; CE = 1'b0; INP_VALID = 2'b00;
    push("reset_mid_wait", cyc, 9'h000, 6'b000000);
    @(negedge clk);
    RST = 1'b1;
    idle();
    op("and_after_reset", 2'b11, 1'b0, 4'd0, 8'h0F, 8'hFF, 1'b0, 9'h00F, 6'b000000);

    op("sub_3_5",     2'b11, 1'b1, 4'd1,  8'd3,  8'd5,  1'b0, 9'h1FE, 6'b010000);
    op("add_cin",     2'b11, 1'b1, 4'd2,  8'h80, 8'h7F, 1'b1, 9'h100, 6'b100000);
    op("dec_b",       2'b10, 1'b1, 4'd7,  8'h00, 8'h10, 1'b0, 9'h00F, 6'b000000);
    op("inc_a_no_a",  2'b10, 1'b1, 4'd4,  8'h05, 8'h00, 1'b0, 9'h000, 6'b000001);
    op("iv_00",       2'b00, 1'b0, 4'd0,  8'h12, 8'h34, 1'b0, 9'h000, 6'b000001);
    op("arith_cmd12", 2'b11, 1'b1, 4'd12, 8'h12, 8'h34, 1'b0, 9'h000, 6'b000001);
    op("logic_cmd14", 2'b11, 1'b0, 4'd14, 8'h12, 8'h34, 1'b0, 9'h000, 6'b000001);

    for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
    while (sb.size() != 0) begin
      exp_t x;
      x = sb.pop_front();
      n_cmp++;
      n_bad++;
      $display("FAIL %s: got no check by cycle %0d, required check at cycle %0d",
               x.name, cyc, x.due);
    end
    if (n_cmp < 26) begin
      n_bad++;
      $display("FAIL check_count: got %0d comparisons, required at least 26", n_cmp);
    end
    if (n_bad == 0) $display("PASS: all %0d checks matched", n_cmp);
    else            $display("FAIL: %0d of %0d checks mismatched", n_bad, n_cmp);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
